exec_muldiv: RTL and testbench

Parametrised multi-cycle integer multiply/divide unit attached beside the execute stage of the swt16 pipeline. It accepts one operation per start pulse and computes signed multiply (low or high half), signed quotient or signed remainder. It uses an iterative one-bit-per-cycle datapath and raises a busy/stall indication so that decode holds the pipe. The result returns with its destination register index and a one-cycle valid pulse, which the write-back path uses.

---
 rtl/exec_muldiv_if.sv | 28 ++
 rtl/exec_muldiv.sv | 146 ++++++++++++++
 tb/tb_exec_muldiv.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/exec_muldiv_if.sv
// Request/result bundle between the execute stage and the multi-cycle mul/div unit.
interface exec_muldiv_if #(
  parameter int IALU_WORD_WIDTH = 16,
  parameter int REG_IDX_WIDTH   = 4
);
  logic                       in_start;
  logic [1:0]                 in_op;
  logic [IALU_WORD_WIDTH-1:0] in_src1;
  logic [IALU_WORD_WIDTH-1:0] in_src2;
  logic [REG_IDX_WIDTH-1:0]   in_res_reg_idx;
  logic                       in_flush;
  logic                       out_busy;
  logic                       out_stall;
  logic [IALU_WORD_WIDTH-1:0] out_res;
  logic [REG_IDX_WIDTH-1:0]   out_res_reg_idx;
  logic                       out_res_valid;
  logic                       out_div_by_zero;

  modport master (
    output in_start, in_op, in_src1, in_src2, in_res_reg_idx, in_flush,
    input  out_busy, out_stall, out_res, out_res_reg_idx, out_res_valid, out_div_by_zero
  );

  modport slave (
    input  in_start, in_op, in_src1, in_src2, in_res_reg_idx, in_flush,
    output out_busy, out_stall, out_res, out_res_reg_idx, out_res_valid, out_div_by_zero
  );
endinterface

// File: rtl/exec_muldiv.sv
// Iterative signed multiply/divide unit: one product or quotient bit per RUN cycle,
// magnitudes in the datapath, sign fixup in DONE.
module exec_muldiv #(
  parameter int IALU_WORD_WIDTH = 16,
  parameter int REG_IDX_WIDTH   = 4
) (
  input logic         clk,
  input logic         rst,
  exec_muldiv_if.slave bus
);
  localparam int W  = IALU_WORD_WIDTH;
  localparam int CW = $clog2(W + 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t                   r_state;
  state_t                   w_state_nx;
  logic [CW-1:0]            r_cnt;
  logic [1:0]               r_op;
  logic                     r_neg;
  logic                     r_neg_a;
  logic                     r_dbz;
  logic [W:0]               r_hi;
  logic [W-1:0]             r_lo;
  logic [W-1:0]             r_m;
  logic [REG_IDX_WIDTH-1:0] r_idx;
  logic [REG_IDX_WIDTH-1:0] r_idx_hold;
  logic [W-1:0]             r_res_hold;

  logic                     w_accept;
  logic                     w_div_zero;
  logic                     w_valid;
  logic [W-1:0]             w_abs1;
  logic [W-1:0]             w_abs2;
  logic [W:0]               w_sum;
  logic [W:0]               w_shift;
  logic                     w_ge;
  logic [2*W-1:0]           w_prod;
  logic [2*W-1:0]           w_prod_s;
  logic [W-1:0]             w_fix;

  assign w_div_zero = bus.in_op[1] && (bus.in_src2 == '0);
  assign w_abs1     = bus.in_src1[W-1] ? ('0 - bus.in_src1) : bus.in_src1;
  assign w_abs2     = bus.in_src2[W-1] ? ('0 - bus.in_src2) : bus.in_src2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nx;
  end

  always_comb begin
    w_state_nx = r_state;
    w_accept   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.in_start && !bus.in_flush) begin
          w_accept   = 1'b1;
          w_state_nx = w_div_zero ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        if (bus.in_flush)              w_state_nx = S_IDLE;
        else if (r_cnt == CW'(1))      w_state_nx = S_DONE;
      end
      S_DONE: begin
        if (bus.in_flush) begin
          w_state_nx = S_IDLE;
        end else if (bus.in_start) begin
          w_accept   = 1'b1;
          w_state_nx = w_div_zero ? S_DONE : S_RUN;
        end else begin
          w_state_nx = S_IDLE;
        end
      end
      default: w_state_nx = S_IDLE;
    endcase
  end

  // Shift-add keeps the running high half in r_hi and shifts multiplier bits out of r_lo.
  assign w_sum   = r_lo[0] ? (r_hi + {1'b0, r_m}) : r_hi;
  assign w_shift = {r_hi[W-1:0], r_lo[W-1]};
  assign w_ge    = (w_shift >= {1'b0, r_m});

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt      <= '0;
      r_op       <= '0;
      r_neg      <= 1'b0;
      r_neg_a    <= 1'b0;
      r_dbz      <= 1'b0;
      r_hi       <= '0;
      r_lo       <= '0;
      r_m        <= '0;
      r_idx      <= '0;
      r_idx_hold <= '0;
      r_res_hold <= '0;
    end else begin
      if (w_accept) begin
        r_cnt   <= CW'(W);
        r_op    <= bus.in_op;
        r_neg   <= bus.in_src1[W-1] ^ bus.in_src2[W-1];
        r_neg_a <= bus.in_src1[W-1];
        r_dbz   <= w_div_zero;
        r_idx   <= bus.in_res_reg_idx;
        r_m     <= bus.in_op[1] ? w_abs2 : w_abs1;
        r_lo    <= bus.in_op[1] ? w_abs1 : w_abs2;
        r_hi    <= w_div_zero ? {1'b0, w_abs1} : '0;
      end else if (r_state == S_RUN && !bus.in_flush) begin
        r_cnt <= r_cnt - CW'(1);
        if (r_op[1]) begin
          r_hi <= w_ge ? (w_shift - {1'b0, r_m}) : w_shift;
          r_lo <= {r_lo[W-2:0], w_ge};
        end else begin
          r_hi <= {1'b0, w_sum[W:1]};
          r_lo <= {w_sum[0], r_lo[W-1:1]};
        end
      end
      if (w_valid) begin
        r_res_hold <= w_fix;
        r_idx_hold <= r_idx;
      end
    end
  end

  assign w_prod   = {r_hi[W-1:0], r_lo};
  assign w_prod_s = r_neg ? ({(2*W){1'b0}} - w_prod) : w_prod;

  // A zero divisor parks the dividend magnitude in r_hi so the remainder fixup restores it.
  always_comb begin
    w_fix = '0;
    case (r_op)
      2'b00: w_fix = w_prod_s[W-1:0];
      2'b01: w_fix = w_prod_s[2*W-1:W];
      2'b10: w_fix = r_dbz ? '1 : (r_neg ? ('0 - r_lo) : r_lo);
      default: w_fix = r_neg_a ? ('0 - r_hi[W-1:0]) : r_hi[W-1:0];
    endcase
  end

  assign w_valid             = (r_state == S_DONE) && !bus.in_flush;
  assign bus.out_busy        = (r_state != S_IDLE);
  assign bus.out_stall       = bus.out_busy || (bus.in_start && !bus.in_flush);
  assign bus.out_res         = w_valid ? w_fix : r_res_hold;
  assign bus.out_res_reg_idx = w_valid ? r_idx : r_idx_hold;
  assign bus.out_res_valid   = w_valid;
  assign bus.out_div_by_zero = w_valid && r_dbz;
endmodule

// File: tb/tb_exec_muldiv.sv
// Directed bench for exec_muldiv at W=16: arithmetic, latency, flush, back-to-back and reset.
module tb_exec_muldiv;
  logic clk;
  logic rst;
  int   checks;
  int   failures;

  exec_muldiv_if #(.IALU_WORD_WIDTH(16), .REG_IDX_WIDTH(4)) bus ();

  exec_muldiv #(.IALU_WORD_WIDTH(16), .REG_IDX_WIDTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Issues one request and waits for its pulse; lat=0 means no pulse within the budget.
  task automatic do_op(input logic skip_sync, input logic [1:0] op, input logic [15:0] a,
                       input logic [15:0] b, input logic [3:0] idx,
                       output logic [15:0] res, output logic [3:0] ridx, output logic dbz,
                       output int lat, output int busy_cnt,
                       output logic post_valid, output logic post_busy);
    lat = 0; busy_cnt = 0; res = '0; ridx = '0; dbz = 1'b0;
    if (!skip_sync) begin
      @(posedge clk); #1;
    end
    bus.in_start = 1'b1; bus.in_op = op; bus.in_src1 = a; bus.in_src2 = b;
    bus.in_res_reg_idx = idx; bus.in_flush = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk); #1;
      if (c == 1) bus.in_start = 1'b0;
      if (bus.out_busy) busy_cnt++;
      if (bus.out_res_valid) begin
        res = bus.out_res; ridx = bus.out_res_reg_idx; dbz = bus.out_div_by_zero; lat = c;
        break;
      end
    end
    @(posedge clk); #1;
    post_valid = bus.out_res_valid;
    post_busy  = bus.out_busy;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.in_start = 1'b0; bus.in_op = 2'b00; bus.in_src1 = '0; bus.in_src2 = '0;
    bus.in_res_reg_idx = '0; bus.in_flush = 1'b0;
    #12;
    checks++; if (bus.out_busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%0b exp=0", bus.out_busy); end
    checks++; if (bus.out_res !== 16'h0000) begin failures++; $display("FAIL reset_res got=%h exp=0000", bus.out_res); end
    checks++; if (bus.out_res_reg_idx !== 4'h0) begin failures++; $display("FAIL reset_idx got=%h exp=0", bus.out_res_reg_idx); end
    checks++; if (bus.out_res_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%0b exp=0", bus.out_res_valid); end
    checks++; if (bus.out_div_by_zero !== 1'b0) begin failures++; $display("FAIL reset_dbz got=%0b exp=0", bus.out_div_by_zero); end
    checks++; if (bus.out_stall !== 1'b0) begin failures++; $display("FAIL reset_stall_idle got=%0b exp=0", bus.out_stall); end
    bus.in_start = 1'b1; #1;
    checks++; if (bus.out_stall !== 1'b1) begin failures++; $display("FAIL stall_on_start got=%0b exp=1", bus.out_stall); end
    bus.in_flush = 1'b1; #1;
    checks++; if (bus.out_stall !== 1'b0) begin failures++; $display("FAIL stall_flush_masks got=%0b exp=0", bus.out_stall); end
    bus.in_start = 1'b0; bus.in_flush = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  // op, src1, src2, idx, expected result, expected div_by_zero, expected latency
  task automatic run_table(input string name, input int n, input logic [1:0] ops[],
                           input logic [15:0] va[], input logic [15:0] vb[],
                           input logic [3:0] vi[], input logic [15:0] ve[],
                           input logic exp_dbz, input int exp_lat);
    logic [15:0] res; logic [3:0] ridx; logic dbz; int lat; int bc; logic pv; logic pb;
    for (int i = 0; i < n; i++) begin
      do_op(1'b0, ops[i], va[i], vb[i], vi[i], res, ridx, dbz, lat, bc, pv, pb);
      checks++; if (res !== ve[i]) begin failures++; $display("FAIL %s[%0d]_res got=%h exp=%h", name, i, res, ve[i]); end
      checks++; if (ridx !== vi[i]) begin failures++; $display("FAIL %s[%0d]_idx got=%h exp=%h", name, i, ridx, vi[i]); end
      checks++; if (dbz !== exp_dbz) begin failures++; $display("FAIL %s[%0d]_dbz got=%0b exp=%0b", name, i, dbz, exp_dbz); end
      checks++; if (lat !== exp_lat) begin failures++; $display("FAIL %s[%0d]_latency got=%0d exp=%0d", name, i, lat, exp_lat); end
      checks++; if (bc !== exp_lat) begin failures++; $display("FAIL %s[%0d]_busy_cycles got=%0d exp=%0d", name, i, bc, exp_lat); end
      checks++; if (pv !== 1'b0 || pb !== 1'b0) begin failures++; $display("FAIL %s[%0d]_after_pulse valid=%0b busy=%0b exp=0/0", name, i, pv, pb); end
    end
  endtask

  task automatic test_mul();
    logic [1:0]  ops[] = '{2'b00, 2'b01, 2'b01, 2'b00, 2'b00};
    logic [15:0] va[]  = '{16'h0007, 16'hFFFE, 16'h4000, 16'h8000, 16'h0003};
    logic [15:0] vb[]  = '{16'hFFFD, 16'h0003, 16'h0004, 16'hFFFF, 16'h0004};
    logic [3:0]  vi[]  = '{4'd5, 4'd1, 4'd2, 4'd3, 4'd15};
    logic [15:0] ve[]  = '{16'hFFEB, 16'hFFFF, 16'h0001, 16'h8000, 16'h000C};
    run_table("mul", 5, ops, va, vb, vi, ve, 1'b0, 17);
  endtask

  task automatic test_div();
    logic [1:0]  ops[] = '{2'b10, 2'b11, 2'b10, 2'b11, 2'b10, 2'b11};
    logic [15:0] va[]  = '{16'hFFF9, 16'hFFF9, 16'h8000, 16'h8000, 16'h0007, 16'h0007};
    logic [15:0] vb[]  = '{16'h0002, 16'h0002, 16'hFFFF, 16'hFFFF, 16'hFFFE, 16'hFFFE};
    logic [3:0]  vi[]  = '{4'd4, 4'd6, 4'd7, 4'd8, 4'd12, 4'd13};
    logic [15:0] ve[]  = '{16'hFFFD, 16'hFFFF, 16'h8000, 16'h0000, 16'hFFFD, 16'h0001};
    run_table("div", 6, ops, va, vb, vi, ve, 1'b0, 17);
  endtask

  task automatic test_div_zero();
    logic [1:0]  ops[] = '{2'b10, 2'b11, 2'b11};
    logic [15:0] va[]  = '{16'h0005, 16'h0005, 16'hFFF9};
    logic [15:0] vb[]  = '{16'h0000, 16'h0000, 16'h0000};
    logic [3:0]  vi[]  = '{4'd10, 4'd14, 4'd9};
    logic [15:0] ve[]  = '{16'hFFFF, 16'h0005, 16'hFFF9};
    run_table("divzero", 3, ops, va, vb, vi, ve, 1'b1, 1);
  endtask

  task automatic test_flush();
    logic [15:0] res; logic [3:0] ridx; logic dbz; int lat; int bc; logic pv; logic pb;
    logic saw_valid;
    do_op(1'b0, 2'b00, 16'h0003, 16'h0004, 4'd2, res, ridx, dbz, lat, bc, pv, pb);
    checks++; if (res !== 16'h000C) begin failures++; $display("FAIL flush_baseline got=%h exp=000c", res); end
    saw_valid = 1'b0;
    @(posedge clk); #1;
    bus.in_start = 1'b1; bus.in_op = 2'b00; bus.in_src1 = 16'd100; bus.in_src2 = 16'd100;
    bus.in_res_reg_idx = 4'd9;
    for (int c = 1; c <= 5; c++) begin
      @(posedge clk); #1;
      if (bus.out_res_valid) saw_valid = 1'b1;
      if (c == 1) bus.in_start = 1'b0;
      if (c == 5) begin
        bus.in_start = 1'b1; bus.in_flush = 1'b1; #1;
        checks++; if (bus.out_stall !== 1'b1) begin failures++; $display("FAIL flush_stall_in_run got=%0b exp=1", bus.out_stall); end
      end
    end
    @(posedge clk); #1;
    if (bus.out_res_valid) saw_valid = 1'b1;
    checks++; if (bus.out_busy !== 1'b0) begin failures++; $display("FAIL flush_busy got=%0b exp=0", bus.out_busy); end
    checks++; if (saw_valid !== 1'b0) begin failures++; $display("FAIL flush_no_pulse got=%0b exp=0", saw_valid); end
    checks++; if (bus.out_res !== 16'h000C) begin failures++; $display("FAIL flush_res_held got=%h exp=000c", bus.out_res); end
    checks++; if (bus.out_res_reg_idx !== 4'd2) begin failures++; $display("FAIL flush_idx_held got=%h exp=2", bus.out_res_reg_idx); end
    do_op(1'b1, 2'b00, 16'd100, 16'd100, 4'd9, res, ridx, dbz, lat, bc, pv, pb);
    checks++; if (res !== 16'h2710) begin failures++; $display("FAIL flush_restart_res got=%h exp=2710", res); end
    checks++; if (lat !== 17) begin failures++; $display("FAIL flush_restart_latency got=%0d exp=17", lat); end
  endtask

  task automatic test_flush_in_done();
    logic [15:0] res; logic [3:0] ridx; logic dbz; int lat; int bc; logic pv; logic pb;
    do_op(1'b0, 2'b00, 16'h0002, 16'h0003, 4'd3, res, ridx, dbz, lat, bc, pv, pb);
    @(posedge clk); #1;
    bus.in_start = 1'b1; bus.in_op = 2'b10; bus.in_src1 = 16'h0005; bus.in_src2 = 16'h0000;
    bus.in_res_reg_idx = 4'd7;
    @(posedge clk); #1;
    bus.in_start = 1'b0; bus.in_flush = 1'b1; #1;
    checks++; if (bus.out_res_valid !== 1'b0 || bus.out_div_by_zero !== 1'b0) begin
      failures++; $display("FAIL flush_done_pulse valid=%0b dbz=%0b exp=0/0", bus.out_res_valid, bus.out_div_by_zero); end
    @(posedge clk); #1;
    bus.in_flush = 1'b0;
    checks++; if (bus.out_busy !== 1'b0) begin failures++; $display("FAIL flush_done_busy got=%0b exp=0", bus.out_busy); end
    checks++; if (bus.out_res !== 16'h0006 || bus.out_res_reg_idx !== 4'd3) begin
      failures++; $display("FAIL flush_done_held res=%h idx=%h exp=0006/3", bus.out_res, bus.out_res_reg_idx); end
  endtask

  task automatic test_back_to_back();
    int first; int second;
    logic [15:0] res_a; logic [15:0] res_b; logic [3:0] idx_a; logic [3:0] idx_b;
    first = 0; second = 0; res_a = '0; res_b = '0; idx_a = '0; idx_b = '0;
    @(posedge clk); #1;
    bus.in_start = 1'b1; bus.in_op = 2'b00; bus.in_src1 = 16'h0007; bus.in_src2 = 16'hFFFD;
    bus.in_res_reg_idx = 4'd5;
    for (int c = 1; c <= 50; c++) begin
      @(posedge clk); #1;
      if (c == 1) begin
        bus.in_op = 2'b10; bus.in_src1 = 16'hFFF9; bus.in_src2 = 16'h0002; bus.in_res_reg_idx = 4'd11;
      end
      if (first != 0 && c == first + 1) begin
        bus.in_start = 1'b0;
        checks++; if (bus.out_busy !== 1'b1) begin failures++; $display("FAIL b2b_busy_after_a got=%0b exp=1", bus.out_busy); end
      end
      if (bus.out_res_valid) begin
        if (first == 0) begin
          first = c; res_a = bus.out_res; idx_a = bus.out_res_reg_idx;
        end else begin
          second = c; res_b = bus.out_res; idx_b = bus.out_res_reg_idx;
          break;
        end
      end
    end
    bus.in_start = 1'b0;
    checks++; if (first !== 17) begin failures++; $display("FAIL b2b_a_latency got=%0d exp=17", first); end
    checks++; if (res_a !== 16'hFFEB || idx_a !== 4'd5) begin failures++; $display("FAIL b2b_a_res got=%h/%h exp=ffeb/5", res_a, idx_a); end
    checks++; if (second !== 34) begin failures++; $display("FAIL b2b_b_latency got=%0d exp=34", second); end
    checks++; if (res_b !== 16'hFFFD || idx_b !== 4'd11) begin failures++; $display("FAIL b2b_b_res got=%h/%h exp=fffd/b", res_b, idx_b); end
  endtask

  task automatic test_async_reset();
    logic [15:0] res; logic [3:0] ridx; logic dbz; int lat; int bc; logic pv; logic pb;
    int pulses;
    pulses = 0;
    @(posedge clk); #1;
    bus.in_start = 1'b1; bus.in_op = 2'b00; bus.in_src1 = 16'h0009; bus.in_src2 = 16'h0009;
    bus.in_res_reg_idx = 4'd6;
    for (int c = 1; c <= 8; c++) begin
      @(posedge clk); #1;
      if (c == 1) bus.in_start = 1'b0;
    end
    checks++; if (bus.out_res === 16'h0000) begin failures++; $display("FAIL areset_precondition res=%h exp=nonzero", bus.out_res); end
    #3; rst = 1'b1; #1;
    checks++; if (bus.out_busy !== 1'b0) begin failures++; $display("FAIL areset_busy got=%0b exp=0", bus.out_busy); end
    checks++; if (bus.out_res !== 16'h0000) begin failures++; $display("FAIL areset_res got=%h exp=0000", bus.out_res); end
    checks++; if (bus.out_res_reg_idx !== 4'h0) begin failures++; $display("FAIL areset_idx got=%h exp=0", bus.out_res_reg_idx); end
    checks++; if (bus.out_res_valid !== 1'b0 || bus.out_div_by_zero !== 1'b0) begin
      failures++; $display("FAIL areset_valid valid=%0b dbz=%0b exp=0/0", bus.out_res_valid, bus.out_div_by_zero); end
    @(posedge clk); #1;
    rst = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      if (bus.out_res_valid) pulses++;
    end
    checks++; if (pulses !== 0) begin failures++; $display("FAIL areset_no_pulse got=%0d exp=0", pulses); end
    do_op(1'b0, 2'b00, 16'h0009, 16'h0009, 4'd6, res, ridx, dbz, lat, bc, pv, pb);
    checks++; if (res !== 16'h0051 || lat !== 17) begin failures++; $display("FAIL areset_recover res=%h lat=%0d exp=0051/17", res, lat); end
  endtask

  initial begin
    checks = 0; failures = 0;
    test_reset();
    test_mul();
    test_div();
    test_div_zero();
    test_flush();
    test_flush_in_done();
    test_back_to_back();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
